// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a uart_tx: buffers CPU writes and feeds the transmitter
// one frame at a time, using a start pulse and the transmitter's busy handshake.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          tx_busy,
   output logic          tx_en,
   output logic [7:0]    tx_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          clr_overflow
);

   if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two from 2 to 64");
   end

   localparam logic [AW:0] LevelMax = (AW + 1)'(DEPTH);
   localparam logic [1:0]  TmoLast  = 2'd3;  // four cycles in WaitBusy before giving up

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWaitBusy,
      StWaitDone
   } state_e;

   // Storage is deliberately not reset; only pointers and level define validity.
   logic [7:0]    mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          overflow_q, overflow_d;
   state_e        state_q, state_d;
   logic [1:0]    tmo_q, tmo_d;
   logic          tx_en_q, tx_en_d;
   logic [7:0]    tx_data_q, tx_data_d;

   logic          empty_w;
   logic          full_w;
   logic          pop;
   logic          push;
   logic          drop;

   // Occupancy flags and the enqueue/dequeue/drop decisions for this cycle.
   always_comb begin
      empty_w = (level_q == '0);
      full_w  = (level_q == LevelMax);
      // Dequeue happens on the same edge the FSM leaves Idle for Launch.
      pop     = (state_q == StIdle) && !empty_w && !tx_busy;
      // A write while full still fits if the head leaves on the same edge.
      push    = wr_en && !reset && (!full_w || pop);
      drop    = wr_en && !reset && full_w && !pop;
   end

   // Pointer, level and sticky overflow next-state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase

      // Clear wins over a drop in the same cycle.
      if (clr_overflow) begin
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
      end
   end

   // Drain FSM: launch one byte, wait for busy to rise (or time out), wait for it to fall.
   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      tx_data_d = tx_data_q;

      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d   = StLaunch;
               tx_data_d = mem_q[rd_ptr_q];
            end
         end
         StLaunch: begin
            state_d = StWaitBusy;
            tmo_d   = '0;
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end else if (tmo_q == TmoLast) begin
               // Transmitter never acknowledged; treat the byte as sent.
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 2'd1;
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Start pulse is registered so it is high exactly while in Launch.
      tx_en_d = (state_d == StLaunch);
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= StIdle;
         tmo_q      <= '0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         tx_en_q    <= tx_en_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Byte storage write port.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign tx_en    = tx_en_q;
   assign tx_data  = tx_data_q;
   assign empty    = empty_w;
   assign full     = full_w;
   assign level    = level_q;
   assign overflow = overflow_q;

   a_level_bound : assert property (@(posedge clk) disable iff (reset) level_q <= LevelMax);
   a_single_pulse : assert property (@(posedge clk) disable iff (reset) tx_en_q |=> !tx_en_q);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes expected bytes, a negedge
// monitor pops them on every tx_en and tracks occupancy against a counting model.
module tb_uart_tx_fifo;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          tx_busy;
   logic          clr_overflow = 1'b0;
   logic          tx_en;
   logic [7:0]    tx_data;
   logic          empty;
   logic          full;
   logic [AW:0]   level;
   logic          overflow;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .tx_busy      (tx_busy),
      .tx_en        (tx_en),
      .tx_data      (tx_data),
      .empty        (empty),
      .full         (full),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   int   n_checks = 0;
   int   n_err = 0;
   logic [7:0] exp_q[$];
   int   acc_cnt = 0;       // accepted writes issued
   int   acc_pending = 0;   // 1 while an accepted write waits for its edge
   int   tx_cnt = 0;        // tx_en pulses seen
   bit   mon_en = 0;
   bit   prev_tx_en = 0;
   bit   busy_hold = 0;
   bit   busy_low = 0;
   int   fix_len = 0;
   int   frame_left = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] b, input bit accept, input bit clr);
      wr_en        = 1'b1;
      wr_data      = b;
      clr_overflow = clr;
      if (accept) begin
         exp_q.push_back(b);
         acc_cnt++;
         acc_pending = 1;
      end
      tick();
      acc_pending  = 0;
      wr_en        = 1'b0;
      clr_overflow = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((exp_q.size() != 0 || !empty) && k < 2000) begin
         tick();
         k++;
      end
      if (k >= 2000) fail("drain_timeout");
      repeat (12) tick();
   endtask

   // Downstream uart_tx model: busy for a frame after each start pulse.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_low) begin
            tx_busy    = 1'b0;
            frame_left = 0;
         end else if (busy_hold) begin
            tx_busy = 1'b1;
         end else begin
            if (tx_en) frame_left = (fix_len > 0) ? fix_len : int'($urandom_range(2, 8));
            else if (frame_left > 0) frame_left--;
            tx_busy = (frame_left > 0);
         end
      end
   end

   // Monitor: ordered byte check on each pulse, plus occupancy model.
   always @(negedge clk) begin
      int exp_lvl;
      if (mon_en) begin
         if (tx_en) begin
            tx_cnt++;
            check("tx_en_single_cycle", int'(prev_tx_en), 0);
            if (exp_q.size() == 0) fail("unexpected_tx_en");
            else check("tx_data_order", int'(tx_data), int'(exp_q.pop_front()));
         end
         exp_lvl = acc_cnt - acc_pending - tx_cnt;
         check("level", int'(level), exp_lvl);
         check("empty", int'(empty), int'(exp_lvl == 0));
         check("full", int'(full), int'(exp_lvl == DEPTH));
      end
      prev_tx_en = tx_en;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      int k;
      int first;
      int second;
      int written;

      // Reset with a write strobe that must be ignored.
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hFF;
      repeat (3) tick();
      @(negedge clk);
      check("rst_level", int'(level), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_tx_en", int'(tx_en), 0);
      check("rst_tx_data", int'(tx_data), 0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      wr_en  = 1'b0;
      mon_en = 1;
      tick();
      check("rst_write_ignored", int'(level), 0);

      // Single byte: level 0->1->0, pulse two cycles after the write cycle.
      do_write(8'h41, 1, 0);
      @(negedge clk);
      check("lat_level1", int'(level), 1);
      check("lat_no_early_tx_en", int'(tx_en), 0);
      @(negedge clk);
      check("lat_level0", int'(level), 0);
      check("lat_tx_en", int'(tx_en), 1);
      check("lat_tx_data", int'(tx_data), 8'h41);
      @(posedge clk);
      #1;
      wait_idle();

      // Burst fill while busy held high, then overflow handling.
      busy_hold = 1;
      repeat (2) tick();
      for (int i = 0; i < 8; i++) do_write(8'(8'h30 + i), 1, 0);
      check("burst_full", int'(full), 1);
      check("burst_level", int'(level), 8);
      check("burst_no_overflow", int'(overflow), 0);
      do_write(8'h55, 0, 0);
      check("ovf_set", int'(overflow), 1);
      check("ovf_level_kept", int'(level), 8);
      do_write(8'h66, 0, 1);
      check("ovf_clr_priority", int'(overflow), 0);
      do_write(8'h77, 0, 0);
      check("ovf_set_again", int'(overflow), 1);
      tick();
      check("ovf_sticky", int'(overflow), 1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("ovf_clr", int'(overflow), 0);
      busy_hold = 0;
      wait_idle();

      // Randomized writes interleaved with random-length frames; wraps many times.
      written = 0;
      for (int cyc = 0; cyc < 3000 && written < 40; cyc++) begin
         if ((acc_cnt - tx_cnt) < DEPTH && $urandom_range(0, 2) == 0) begin
            do_write(8'($urandom), 1, 0);
            written++;
         end else begin
            tick();
         end
      end
      check("rand_all_written", written, 40);
      wait_idle();
      check("rand_no_overflow", int'(overflow), 0);

      // Stuck-low busy: one pulse per byte, timeout then relaunch gap.
      busy_low = 1;
      repeat (2) tick();
      t0 = tx_cnt;
      do_write(8'h7E, 1, 0);
      repeat (20) tick();
      check("tmo_single_pulse", tx_cnt - t0, 1);
      do_write(8'h11, 1, 0);
      do_write(8'h22, 1, 0);
      first  = -1;
      second = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_en) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
      end
      // Launch(1) + WaitBusy timeout(4) + Idle(1) between pulse starts.
      check("tmo_relaunch_gap", second - first, 6);
      @(posedge clk);
      #1;
      busy_low = 0;
      wait_idle();

      // Reset mid-transmission with three bytes queued.
      fix_len = 20;
      t0 = tx_cnt;
      do_write(8'hA0, 1, 0);
      k = 0;
      while (tx_cnt == t0 && k < 20) begin
         tick();
         k++;
      end
      if (k >= 20) fail("first_pulse_wait");
      do_write(8'hB1, 1, 0);
      do_write(8'hB2, 1, 0);
      do_write(8'hB3, 1, 0);
      repeat (2) tick();
      check("pre_reset_level", int'(level), 3);
      check("pre_reset_busy", int'(tx_busy), 1);
      mon_en = 0;
      reset  = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      acc_cnt = 0;
      tx_cnt  = 0;
      mon_en  = 1;
      @(negedge clk);
      check("post_reset_level", int'(level), 0);
      check("post_reset_empty", int'(empty), 1);
      check("post_reset_tx_en", int'(tx_en), 0);
      @(posedge clk);
      #1;
      repeat (30) tick();
      check("no_tx_after_reset", tx_cnt, 0);
      fix_len = 0;
      do_write(8'hC3, 1, 0);
      wait_idle();
      check("tx_after_new_write", tx_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the FIFO capacity in bytes; only powers of two from 2 to 64 are legal.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), giving the pointer width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: CPU byte-write strobe, i.e. is_data qualified by the UART data address decode.
REQ-006 SHALL have port wr_data, input, 8 bits: the byte to enqueue.
REQ-007 SHALL have port tx_busy, input, 1 bit: busy flag from the downstream uart_tx.
REQ-008 SHALL have port tx_en, output, 1 bit: single-cycle start pulse to uart_tx.
REQ-009 SHALL have port tx_data, output, 8 bits: byte presented to uart_tx, held stable while tx_en is high.
REQ-010 SHALL have port empty, output, 1 bit: FIFO holds 0 bytes.
REQ-011 SHALL have port full, output, 1 bit: FIFO holds DEPTH bytes.
REQ-012 SHALL have port level, output, AW+1 bits: current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-014 SHALL have port clr_overflow, input, 1 bit: clears overflow.

Function
REQ-015 SHALL store bytes in a DEPTH-entry circular buffer addressed by AW-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-016 SHALL enqueue wr_data on wr_en when not full; level reflects the new byte on the next cycle.
REQ-017 SHALL drop a write attempted while full, leaving contents, pointers and level unchanged, and set overflow on the next cycle.
REQ-018 SHALL give clr_overflow priority over a simultaneous overflow-setting event, so overflow ends cleared.
REQ-019 SHALL run the drain FSM through states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-020 SHALL move IDLE to LAUNCH when not empty and tx_busy is low; on that edge it loads tx_data from the head entry and advances the read pointer.
REQ-021 SHALL, in LAUNCH, assert tx_en for exactly one cycle, then go to WAIT_BUSY.
REQ-022 SHALL move WAIT_BUSY to WAIT_DONE when tx_busy is high.
REQ-023 SHALL, in WAIT_BUSY, return to IDLE after 4 cycles if tx_busy never asserts (timeout guard); the byte counts as sent.
REQ-024 SHALL move WAIT_DONE to IDLE when tx_busy is low.
REQ-025 SHALL launch at most one byte per FSM round trip; the earliest next tx_en is 1 cycle after the FSM re-enters IDLE.
REQ-026 SHALL, on a simultaneous write and dequeue, keep level unchanged and perform both operations.
REQ-027 SHALL accept a write on the cycle it leaves full via dequeue only if the dequeue happens that same cycle; full is evaluated on registered level.
REQ-028 SHALL give a write into an empty FIFO with tx_busy low a latency of 2 cycles from the wr_en edge to the tx_en high cycle.
REQ-029 SHALL hold tx_data from the load edge until the next load.
REQ-030 SHALL derive empty and full combinationally from level; level SHALL never exceed DEPTH or underflow.

Reset
REQ-031 SHALL, while reset is high, set the pointers to 0, level to 0, overflow to 0, the FSM to IDLE, tx_en to 0 and tx_data to 0x00; empty reads 1 and full reads 0.
REQ-032 SHALL, on reset asserted mid-transmission, discard all queued bytes; uart_tx finishes its current frame independently and the FSM ignores the remaining busy period.
REQ-033 SHALL ignore wr_en during the reset cycle.
REQ-034 SHALL NOT reset the storage array; contents are don't-care after reset.

Verification
REQ-035 SHALL pass this test: write 0x41 into an empty FIFO with tx_busy tied to a uart_tx model -> tx_en pulses 2 cycles later with tx_data=0x41, and level goes 0->1->0.
REQ-036 SHALL pass this test: burst-write 0x30..0x37 (DEPTH=8) while tx_busy is held high -> full=1 and level=8; after tx_busy releases, the bytes emerge in order 0x30..0x37, one tx_en per frame.
REQ-037 SHALL pass this test: write a 9th byte 0x55 while full -> overflow=1 and 0x55 is never transmitted; then pulse clr_overflow together with another full write -> overflow=0.
REQ-038 SHALL pass this test: write 20 bytes with drains interleaved so the pointers wrap twice -> the output sequence matches the input, and level never exceeds 8.
REQ-039 SHALL pass this test: hold tx_busy stuck low and write 0x7E -> one tx_en pulse, the timeout returns the FSM to IDLE within 6 cycles, and no repeat pulse occurs.
REQ-040 SHALL pass this test: assert reset for 1 cycle while 3 bytes are queued and the FSM is in WAIT_DONE -> next cycle level=0, empty=1 and tx_en=0, with no further tx_en until a new write.
